// File: rtl/vx_icache_tcm_responder_if.sv
// Fetch-side request/response bundle for the I-cache protocol; the fetch stage is the master and
// the cache or TCM is the slave.
interface vx_icache_tcm_responder_if #(
  parameter int unsigned TAG_WIDTH = 8
);
  logic                 icache_req_valid;
  logic [29:0]          icache_req_addr;
  logic [TAG_WIDTH-1:0] icache_req_tag;
  logic                 icache_req_ready;
  logic                 icache_rsp_valid;
  logic [31:0]          icache_rsp_data;
  logic [TAG_WIDTH-1:0] icache_rsp_tag;
  logic                 icache_rsp_ready;

  modport master (
    output icache_req_valid, icache_req_addr, icache_req_tag, icache_rsp_ready,
    input  icache_req_ready, icache_rsp_valid, icache_rsp_data, icache_rsp_tag
  );

  modport slave (
    input  icache_req_valid, icache_req_addr, icache_req_tag, icache_rsp_ready,
    output icache_req_ready, icache_rsp_valid, icache_rsp_data, icache_rsp_tag
  );
endinterface

// File: rtl/vx_icache_tcm_responder.sv
// Tightly-coupled instruction SRAM answering I-cache requests in order through a credit-protected
// response FIFO. Define VX_ICACHE_TCM_PERF_EN to add request/stall performance counters.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_icache_tcm_responder #(
  parameter int unsigned SIZE      = 1024,
  parameter int unsigned TAG_WIDTH = 8,
  parameter int unsigned RSP_DEPTH = 4,
  localparam int unsigned IDX_W    = $clog2(SIZE)
) (
  input  logic                           clk,
  input  logic                           reset,
  vx_icache_tcm_responder_if.slave       bus,
  input  logic                           init_wr_en,
  input  logic [IDX_W-1:0]               init_wr_addr,
  input  logic [31:0]                    init_wr_data
`ifdef VX_ICACHE_TCM_PERF_EN
  ,
  output logic [`PERF_CTR_BITS-1:0]      perf_reqs,
  output logic [`PERF_CTR_BITS-1:0]      perf_req_stalls,
  output logic [`PERF_CTR_BITS-1:0]      perf_rsp_stalls
`endif
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W:0]   DepthOcc = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] CntFull  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PtrLast  = PTR_W'(RSP_DEPTH - 1);

  logic [31:0]          mem [SIZE];
  logic                 s1_valid_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;
  logic [31:0]          s1_data_q;
  logic [31:0]          fifo_data [RSP_DEPTH];
  logic [TAG_WIDTH-1:0] fifo_tag  [RSP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W:0]       occ;
  logic                 req_ready, rsp_valid, req_fire, push, pop;
  logic                 unused_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PtrLast) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cover both the FIFO and the read in flight, so S1 never pushes into a full FIFO.
  assign occ         = {1'b0, count_q} + (CNT_W + 1)'(s1_valid_q);
  assign req_ready   = (occ < DepthOcc) && !reset;
  assign rsp_valid   = (count_q != '0);
  assign req_fire    = bus.icache_req_valid && req_ready;
  assign push        = s1_valid_q;
  assign pop         = rsp_valid && bus.icache_rsp_ready;
  assign unused_addr = ^bus.icache_req_addr[29:IDX_W];

  assign bus.icache_req_ready = req_ready;
  assign bus.icache_rsp_valid = rsp_valid;
  assign bus.icache_rsp_data  = fifo_data[rd_ptr_q];
  assign bus.icache_rsp_tag   = fifo_tag[rd_ptr_q];

  // Read-first: a same-cycle init write to the read index is seen only by later reads.
  always_ff @(posedge clk) begin
    if (init_wr_en) begin
      mem[init_wr_addr] <= init_wr_data;
    end
    if (req_fire) begin
      s1_data_q <= mem[bus.icache_req_addr[IDX_W-1:0]];
      s1_tag_q  <= bus.icache_req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= s1_data_q;
      fifo_tag[wr_ptr_q]  <= s1_tag_q;
    end
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= req_fire;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && push && !pop) begin
      assert (count_q < CntFull);
    end
  end
`endif

`ifdef VX_ICACHE_TCM_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_reqs       <= '0;
      perf_req_stalls <= '0;
      perf_rsp_stalls <= '0;
    end else begin
      if (req_fire) begin
        perf_reqs <= perf_reqs + `PERF_CTR_BITS'(1);
      end
      if (bus.icache_req_valid && !req_ready) begin
        perf_req_stalls <= perf_req_stalls + `PERF_CTR_BITS'(1);
      end
      if (rsp_valid && !bus.icache_rsp_ready) begin
        perf_rsp_stalls <= perf_rsp_stalls + `PERF_CTR_BITS'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_icache_tcm_responder.sv
// Directed plus randomized bench for vx_icache_tcm_responder against a queue-based reference model.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module tb_vx_icache_tcm_responder;
  localparam int unsigned SIZE  = 1024;
  localparam int unsigned TW    = 8;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] data;
    logic [TW-1:0] tag;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic init_wr_en = 1'b0;
  logic [9:0] init_wr_addr = '0;
  logic [31:0] init_wr_data = '0;

  vx_icache_tcm_responder_if #(.TAG_WIDTH(TW)) bus ();

`ifdef VX_ICACHE_TCM_PERF_EN
  logic [`PERF_CTR_BITS-1:0] perf_reqs, perf_req_stalls, perf_rsp_stalls;
`endif

  vx_icache_tcm_responder #(
    .SIZE(SIZE),
    .TAG_WIDTH(TW),
    .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .init_wr_en(init_wr_en),
    .init_wr_addr(init_wr_addr),
    .init_wr_data(init_wr_data)
`ifdef VX_ICACHE_TCM_PERF_EN
    ,
    .perf_reqs(perf_reqs),
    .perf_req_stalls(perf_req_stalls),
    .perf_rsp_stalls(perf_rsp_stalls)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] mem_m [SIZE];
  exp_t q[$];
  longint m_reqs = 0, m_req_stalls = 0, m_rsp_stalls = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; check outputs, advance the model, move on.
  task automatic step();
    logic exp_ready, exp_valid;
    #1;
    if (reset) begin
      q.delete();
      m_reqs = 0;
      m_req_stalls = 0;
      m_rsp_stalls = 0;
    end
    exp_ready = !reset && (q.size() < DEPTH);
    exp_valid = !reset && (q.size() > 0) && (q[0].due <= cyc);
    check("req_ready", 64'(bus.icache_req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(bus.icache_rsp_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("rsp_data", 64'(bus.icache_rsp_data), 64'(q[0].data));
      check("rsp_tag", 64'(bus.icache_rsp_tag), 64'(q[0].tag));
    end
`ifdef VX_ICACHE_TCM_PERF_EN
    check("perf_reqs", 64'(perf_reqs), 64'(m_reqs));
    check("perf_req_stalls", 64'(perf_req_stalls), 64'(m_req_stalls));
    check("perf_rsp_stalls", 64'(perf_rsp_stalls), 64'(m_rsp_stalls));
`endif
    if (!reset) begin
      if (bus.icache_req_valid && !exp_ready) m_req_stalls++;
      if (exp_valid && !bus.icache_rsp_ready) m_rsp_stalls++;
      if (exp_valid && bus.icache_rsp_ready) void'(q.pop_front());
      if (bus.icache_req_valid && exp_ready) begin
        q.push_back('{mem_m[int'(bus.icache_req_addr) % SIZE], bus.icache_req_tag, cyc + 2});
        m_reqs++;
      end
    end
    if (init_wr_en) mem_m[init_wr_addr] = init_wr_data;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    bus.icache_req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_req(input logic [29:0] addr, input logic [TW-1:0] tag);
    bus.icache_req_valid = 1'b1;
    bus.icache_req_addr  = addr;
    bus.icache_req_tag   = tag;
  endtask

  int accepted;
  longint base_reqs, base_rstall, base_sstall;

  initial begin
    bus.icache_req_valid = 1'b0;
    bus.icache_req_addr  = '0;
    bus.icache_req_tag   = '0;
    bus.icache_rsp_ready = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    step();

    // Load the whole image so every read has a known model value.
    for (int i = 0; i < SIZE; i++) begin
      init_wr_en   = 1'b1;
      init_wr_addr = 10'(i);
      init_wr_data = (i == 16) ? 32'hDEADBEEF : (i == 3) ? 32'h11111111 : $urandom;
      step();
    end
    init_wr_en = 1'b0;

    // Two-cycle latency of a single request.
    drive_req(30'h10, TW'(5));
    step();
    bus.icache_req_valid = 1'b0;
    step();
    #1;
    check("t1_valid", 64'(bus.icache_rsp_valid), 64'(1));
    check("t1_data", 64'(bus.icache_rsp_data), 64'h0DEADBEEF);
    check("t1_tag", 64'(bus.icache_rsp_tag), 64'(5));
    step();
    idle(2);

    // Back-to-back stream with ignored upper address bits.
    for (int i = 0; i < 8; i++) begin
      drive_req(30'(($urandom << 10) | 32'(i)), TW'(i));
      step();
    end
    idle(4);

    // Backpressure: exactly DEPTH accepted, then ready drops.
    base_reqs = m_reqs;
    base_rstall = m_req_stalls;
    base_sstall = m_rsp_stalls;
    bus.icache_rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      drive_req(30'($urandom), TW'($urandom));
      #1;
      if (bus.icache_req_ready) accepted++;
      step();
    end
    check("t3_accepted", 64'(accepted), 64'(DEPTH));
`ifdef VX_ICACHE_TCM_PERF_EN
    #1;
    check("t3_perf_reqs", 64'(perf_reqs), 64'(base_reqs + 4));
    check("t3_perf_req_stalls", 64'(perf_req_stalls), 64'(base_rstall + 4));
    check("t3_perf_rsp_stalls", 64'(perf_rsp_stalls), 64'(base_sstall + 6));
`endif
    bus.icache_rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_req(30'($urandom), TW'($urandom));
      step();
    end
    idle(6);

    // Read-first collision on index 3.
    drive_req(30'h3, TW'(8'hA));
    init_wr_en   = 1'b1;
    init_wr_addr = 10'h3;
    init_wr_data = 32'h22222222;
    step();
    init_wr_en = 1'b0;
    drive_req(30'h3, TW'(8'hB));
    step();
    bus.icache_req_valid = 1'b0;
    #1;
    check("t4_old", 64'(bus.icache_rsp_data), 64'h11111111);
    step();
    #1;
    check("t4_new", 64'(bus.icache_rsp_data), 64'h22222222);
    step();
    idle(3);

    // Reset with three requests outstanding.
    bus.icache_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(30'($urandom), TW'(i + 1));
      step();
    end
    bus.icache_req_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("t5_rsp_valid_async", 64'(bus.icache_rsp_valid), 64'(0));
    check("t5_req_ready_async", 64'(bus.icache_req_ready), 64'(0));
    step();
    step();
    reset = 1'b0;
    bus.icache_rsp_ready = 1'b1;
    idle(4);
    drive_req(30'h10, TW'(8'h77));
    step();
    idle(4);

    // Randomized traffic with a mid-run reset.
    for (int i = 0; i < 500; i++) begin
      reset = (i == 250 || i == 251);
      bus.icache_req_valid = ($urandom % 4) != 0;
      bus.icache_req_addr  = 30'($urandom);
      bus.icache_req_tag   = TW'($urandom);
      bus.icache_rsp_ready = ($urandom % 3) != 0;
      init_wr_en   = ($urandom % 5) == 0;
      init_wr_addr = 10'($urandom);
      init_wr_data = $urandom;
      step();
    end
    reset = 1'b0;
    init_wr_en = 1'b0;
    bus.icache_rsp_ready = 1'b1;
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
